// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the hazard controller state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the IF/ID instruction into the fields the hazard logic needs.
module hazard_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_lw,
    output logic        is_mul,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic [4:0]  rs,
    output logic [4:0]  rt
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[15:6];

    assign is_lw   = (op == OP_LW);
    assign is_mul  = (op == OP_RTYPE) && ((funct == FN_MULT) || (funct == FN_MULTU));
    assign uses_rs = !((op == OP_J) || (op == OP_JAL));
    assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// IF/ID stall producer: load-use interlock, multi-cycle multiply stall, branch squash
// and a saturating stall-cycle counter.
//
// state    | meaning
// RUN      | normal issue; branch flush, load-use stall or mult launch decided here
// MUL_BUSY | mult occupies EX; front end held, ID/EX fed nops until cnt reaches 0
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [31:0]      IF_IDinstr,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             IF_IDFlush,
    output logic             ID_EXBubble,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

    logic       is_lw;
    logic       is_mul;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] rs;
    logic [4:0] rt;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       ex_ld_v;
    logic [4:0] ex_ld_rt;
    logic       load_use;
    logic       advance;

    hazard_decode u_decode (
        .instr   (IF_IDinstr),
        .is_lw   (is_lw),
        .is_mul  (is_mul),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .rs      (rs),
        .rt      (rt)
    );

    // $0 is never a real dependency, so a lw targeting it cannot cause a stall.
    assign load_use = ex_ld_v && (ex_ld_rt != 5'd0) &&
                      ((uses_rs && (rs == ex_ld_rt)) || (uses_rt && (rt == ex_ld_rt)));

    assign advance = IF_IDWrite && !ID_EXBubble;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        IF_IDFlush  = 1'b0;
        ID_EXBubble = 1'b0;
        MulBusy     = 1'b0;
        if (rst) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXBubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (BranchTaken) begin
                        IF_IDFlush  = 1'b1;
                        ID_EXBubble = 1'b1;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IF_IDWrite  = 1'b0;
                        ID_EXBubble = 1'b1;
                    end else if (is_mul) begin
                        cnt_nxt   = MUL_LOAD;
                        state_nxt = MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    PCWrite     = 1'b0;
                    IF_IDWrite  = 1'b0;
                    ID_EXBubble = 1'b1;
                    MulBusy     = 1'b1;
                    if (cnt == 4'd0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= 4'd0;
            ex_ld_v  <= 1'b0;
            ex_ld_rt <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (advance) begin
                ex_ld_v  <= is_lw;
                ex_ld_rt <= rt;
            end else begin
                ex_ld_v  <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
        end else if (!IF_IDWrite && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + 1'b1;
        end
    end

endmodule
